i2c_master_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one I2C master FSM among `N` requesters. It accepts byte read/write requests and grants one requester at a time. It drives the master's active-low select, reset-register and control-register inputs with the team's command encodings. It returns read data and completion status, and recovers a hung master with a timeout-driven reset. It sits between the host-side requesters and the I2C master FSM.

---
 rtl/i2c_master_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_i2c_master_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one I2C master FSM among
// N byte requesters, with a timeout-driven reset of a hung master.
module i2c_master_arbiter #(
    parameter int N       = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   rw,
    input  logic [8*N-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic           err,
    output logic [7:0]     rdata,
    output logic           m_select_,
    output logic [7:0]     m_reset_reg,
    output logic [7:0]     m_control,
    output logic [7:0]     m_wdata,
    input  logic           m_done,
    input  logic           m_nack,
    input  logic [7:0]     m_rdata
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [7:0] CMD_READ  = 8'hAA;
    localparam logic [7:0] CMD_WRITE = 8'h55;
    localparam logic [7:0] CMD_NONE  = 8'h00;
    localparam logic [7:0] RST_CMD   = 8'hCC;
    localparam logic [7:0] RST_RUN   = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ABORT,
        S_COMPLETE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   win_q;
    logic            rw_q;
    logic [7:0]      wd_q;
    logic [CW-1:0]   cnt_q;
    logic            ab_q;
    logic            err_q;
    logic [7:0]      rd_q;
    logic            rd_upd_q;
    logic [IW-1:0]   arb_idx;
    logic            found;
    logic [N-1:0]    win_oh;
    logic [N-1:0]    o_gnt;
    logic [N-1:0]    o_done;
    logic            o_sel;
    logic [7:0]      o_ctrl;
    logic [7:0]      o_rr;

    // Round-robin pick: first request at or above ptr, wrapping to 0.
    always_comb begin
        arb_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N]) begin
                found   = 1'b1;
                arb_idx = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    // One-hot form of the latched winner.
    always_comb begin
        win_oh        = '0;
        win_oh[win_q] = 1'b1;
    end

    // Next state and the output values the current state calls for.
    always_comb begin
        state_d = state_q;
        o_gnt   = '0;
        o_done  = '0;
        o_sel   = 1'b1;
        o_ctrl  = CMD_NONE;
        o_rr    = RST_RUN;
        case (state_q)
            S_IDLE: begin
                if (found) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                o_gnt   = win_oh;
                o_sel   = 1'b0;
                o_ctrl  = rw_q ? CMD_READ : CMD_WRITE;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                o_gnt  = win_oh;
                o_sel  = 1'b0;
                o_ctrl = rw_q ? CMD_READ : CMD_WRITE;
                if (m_done)                 state_d = S_COMPLETE;
                else if (cnt_q == CNT_LAST) state_d = S_ABORT;
            end
            S_ABORT: begin
                o_gnt = win_oh;
                o_sel = 1'b0;
                o_rr  = RST_CMD;
                if (ab_q) state_d = S_COMPLETE;
            end
            S_COMPLETE: begin
                o_gnt   = win_oh;
                o_done  = win_oh;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Transaction latches, timeout counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr_q    <= '0;
            win_q    <= '0;
            rw_q     <= 1'b0;
            wd_q     <= '0;
            cnt_q    <= '0;
            ab_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= '0;
            rd_upd_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        win_q <= arb_idx;
                        rw_q  <= rw[arb_idx];
                        wd_q  <= wdata[8*int'(arb_idx) +: 8];
                    end
                end
                S_ISSUE: begin
                    cnt_q    <= '0;
                    ab_q     <= 1'b0;
                    err_q    <= 1'b0;
                    rd_upd_q <= 1'b0;
                end
                S_WAIT: begin
                    if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
                    if (m_done) begin
                        err_q <= m_nack;
                        if (rw_q) begin
                            rd_q     <= m_rdata;
                            rd_upd_q <= 1'b1;
                        end
                    end
                end
                S_ABORT: begin
                    ab_q  <= ~ab_q;
                    err_q <= 1'b1;
                end
                S_COMPLETE: begin
                    ptr_q <= (win_q == IW'(N - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs, one cycle behind the state that selects them.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            gnt         <= '0;
            done        <= '0;
            err         <= 1'b0;
            rdata       <= '0;
            m_select_   <= 1'b1;
            m_reset_reg <= RST_RUN;
            m_control   <= CMD_NONE;
            m_wdata     <= '0;
        end else begin
            gnt         <= o_gnt;
            done        <= o_done;
            m_select_   <= o_sel;
            m_reset_reg <= o_rr;
            m_control   <= o_ctrl;
            err         <= (state_q == S_COMPLETE) && err_q;
            if (state_q == S_ISSUE)
                m_wdata <= wd_q;
            if (state_q == S_COMPLETE && rd_upd_q)
                rdata <= rd_q;
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed checks of grant order, command
// encodings, completion status, timeout recovery and async reset.
module tb_i2c_master_arbiter;

    localparam int N       = 2;
    localparam int TIMEOUT = 8;

    logic           clk = 1'b0;
    logic           rst_;
    logic [N-1:0]   req;
    logic [N-1:0]   rw;
    logic [8*N-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           err;
    logic [7:0]     rdata;
    logic           m_select_;
    logic [7:0]     m_reset_reg;
    logic [7:0]     m_control;
    logic [7:0]     m_wdata;
    logic           m_done;
    logic           m_nack;
    logic [7:0]     m_rdata;

    int tests = 0;
    int fails = 0;
    logic [1:0] exp_order [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    i2c_master_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .req         (req),
        .rw          (rw),
        .wdata       (wdata),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .m_select_   (m_select_),
        .m_reset_reg (m_reset_reg),
        .m_control   (m_control),
        .m_wdata     (m_wdata),
        .m_done      (m_done),
        .m_nack      (m_nack),
        .m_rdata     (m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(input string tag);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (gnt == '0 && i < 20);
        chk(tag, {31'b0, gnt != '0}, 1);
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (done == '0 && i < 20);
        chk(tag, {31'b0, done != '0}, 1);
    endtask

    task automatic pulse_mdone(input logic nack, input logic [7:0] rd);
        m_done  = 1'b1;
        m_nack  = nack;
        m_rdata = rd;
        @(negedge clk);
        m_done  = 1'b0;
        m_nack  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_    = 1'b0;
        req     = '0;
        rw      = '0;
        wdata   = '0;
        m_done  = 1'b0;
        m_nack  = 1'b0;
        m_rdata = '0;
        step(2);
        chk("rst_gnt",   gnt, 0);
        chk("rst_done",  done, 0);
        chk("rst_err",   err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sel",   m_select_, 1);
        chk("rst_rr",    m_reset_reg, 0);
        chk("rst_ctrl",  m_control, 0);
        chk("rst_wd",    m_wdata, 0);
        rst_ = 1'b1;
        step(1);

        // single write with exact cycle timing
        req   = 2'b01;
        rw    = 2'b00;
        wdata = 16'h0057;
        step(1);
        chk("wr_lat",   gnt, 0);
        step(1);
        chk("wr_gnt",   gnt, 2'b01);
        chk("wr_sel",   m_select_, 0);
        chk("wr_ctrl",  m_control, 8'h55);
        chk("wr_wd",    m_wdata, 8'h57);
        step(1);
        m_done = 1'b1;
        step(1);
        m_done = 1'b0;
        chk("wr_early", done, 0);
        step(1);
        chk("wr_done",  done, 2'b01);
        chk("wr_err",   err, 0);
        chk("wr_gnt2",  gnt, 2'b01);
        chk("wr_sel2",  m_select_, 1);
        chk("wr_ctrl2", m_control, 0);
        req = 2'b00;
        step(1);
        chk("wr_done_end", done, 0);
        chk("wr_gnt_end",  gnt, 0);

        // m_done while idle must do nothing
        m_done = 1'b1;
        step(1);
        m_done = 1'b0;
        step(2);
        chk("idle_done", done, 0);
        chk("idle_gnt",  gnt, 0);

        // single read from requester 1
        req   = 2'b10;
        rw    = 2'b10;
        wdata = 16'h3300;
        wait_gnt("rd_wait");
        chk("rd_gnt",  gnt, 2'b10);
        chk("rd_ctrl", m_control, 8'hAA);
        pulse_mdone(1'b0, 8'hA5);
        wait_done("rd_wait_done");
        chk("rd_done", done, 2'b10);
        chk("rd_data", rdata, 8'hA5);
        chk("rd_err",  err, 0);
        req = 2'b00;
        rw  = 2'b00;

        // round-robin with both requests held
        req   = 2'b11;
        wdata = 16'h2211;
        for (int t = 0; t < 4; t++) begin
            wait_gnt("rr_wait");
            chk("rr_gnt", gnt, exp_order[t]);
            chk("rr_wd", m_wdata, (t % 2 != 0) ? 8'h22 : 8'h11);
            pulse_mdone(1'b0, 8'h00);
            wait_done("rr_wait_done");
            chk("rr_done", done, exp_order[t]);
            if (t == 3) req = 2'b00;
        end

        // request dropped and wdata changed mid-transaction
        req = 2'b01;
        wait_gnt("dr_wait");
        chk("dr_gnt", gnt, 2'b01);
        req   = 2'b00;
        wdata = 16'h22EE;
        step(1);
        chk("dr_wd", m_wdata, 8'h11);
        pulse_mdone(1'b0, 8'h00);
        wait_done("dr_wait_done");
        chk("dr_done", done, 2'b01);

        // NACK on a write
        req = 2'b01;
        wait_gnt("nk_wait");
        pulse_mdone(1'b1, 8'h3C);
        wait_done("nk_wait_done");
        chk("nk_done",  done, 2'b01);
        chk("nk_err",   err, 1);
        chk("nk_rdata", rdata, 8'hA5);
        req = 2'b00;

        // timeout: master never completes
        req = 2'b10;
        wait_gnt("to_wait");
        chk("to_gnt", gnt, 2'b10);
        step(8);
        chk("to_rr_pre",   m_reset_reg, 0);
        chk("to_ctrl_pre", m_control, 8'h55);
        step(1);
        chk("to_rr1",      m_reset_reg, 8'hCC);
        chk("to_sel",      m_select_, 0);
        chk("to_ctrl",     m_control, 0);
        chk("to_done_pre", done, 0);
        step(1);
        chk("to_rr2",      m_reset_reg, 8'hCC);
        step(1);
        chk("to_done",     done, 2'b10);
        chk("to_err",      err, 1);
        chk("to_rr_end",   m_reset_reg, 0);
        chk("to_rdata",    rdata, 8'hA5);
        req = 2'b00;

        // normal transaction after a timeout
        req = 2'b01;
        wait_gnt("pt_wait");
        pulse_mdone(1'b0, 8'h00);
        wait_done("pt_wait_done");
        chk("pt_done", done, 2'b01);
        chk("pt_err",  err, 0);
        req = 2'b00;

        // m_done on the last counted WAIT cycle wins over timeout
        req = 2'b10;
        rw  = 2'b10;
        wait_gnt("fc_wait");
        step(7);
        m_done  = 1'b1;
        m_rdata = 8'h5A;
        step(1);
        m_done = 1'b0;
        chk("fc_rr",    m_reset_reg, 0);
        step(1);
        chk("fc_done",  done, 2'b10);
        chk("fc_err",   err, 0);
        chk("fc_rdata", rdata, 8'h5A);
        chk("fc_rr2",   m_reset_reg, 0);
        req = 2'b00;
        rw  = 2'b00;

        // move ptr to 1, then reset in the middle of WAIT
        req = 2'b01;
        wait_gnt("rs_pre_wait");
        pulse_mdone(1'b0, 8'h00);
        wait_done("rs_pre_wait_done");
        chk("rs_pre_done", done, 2'b01);
        req = 2'b10;
        wait_gnt("rs_wait");
        chk("rs_gnt", gnt, 2'b10);
        #2 rst_ = 1'b0;
        #1;
        chk("rs_gnt0", gnt, 0);
        chk("rs_sel",  m_select_, 1);
        chk("rs_ctrl", m_control, 0);
        @(negedge clk);
        chk("rs_done", done, 0);
        step(1);
        rst_ = 1'b1;
        req  = 2'b11;
        wait_gnt("rs_tie_wait");
        chk("rs_tie", gnt, 2'b01);
        pulse_mdone(1'b0, 8'h00);
        wait_done("rs_tie_wait_done");
        chk("rs_tie_done", done, 2'b01);
        req = 2'b00;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
